pw_utmi_tx: RTL and testbench

//  UTMI transmit engine: drives fe_data-out/fe_txvalid/fe_opmode on the FE PHY to inject one USB

---
 rtl/pw_utmi_tx_pkg.sv | 17 +
 rtl/pw_utmi_tx_buffer.sv | 33 +++
 rtl/pw_utmi_tx.sv | 179 +++++++++++++++++
 tb/tb_pw_utmi_tx.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pw_utmi_tx_pkg.sv
// pw_utmi_tx shared types: UTMI opmode codes and transmit FSM states.
// No ports; imported by pw_utmi_tx and pw_utmi_tx_buffer.
package pw_utmi_tx_pkg;

  localparam logic [1:0] OPMODE_NORMAL     = 2'b00;
  localparam logic [1:0] OPMODE_NONDRIVING = 2'b01;
  localparam logic [1:0] OPMODE_NOSTUFF    = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_GAP,
    ST_SEND,
    ST_TAIL
  } tx_state_e;

endpackage

// File: rtl/pw_utmi_tx_buffer.sv
// Packet byte buffer: sync write port, sync (1-cycle) read port with enable.
// Ports: clk_i, rst_i, wr_i/wr_addr_i/wr_data_i, rd_i/rd_addr_i, rd_data_o.
module pw_utmi_tx_buffer #(
  parameter int pADDR_WIDTH = 6
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   wr_i,
  input  logic [pADDR_WIDTH-1:0] wr_addr_i,
  input  logic [7:0]             wr_data_i,
  input  logic                   rd_i,
  input  logic [pADDR_WIDTH-1:0] rd_addr_i,
  output logic [7:0]             rd_data_o
);

  localparam int DEPTH = 2 ** pADDR_WIDTH;

  logic [7:0] mem_q [DEPTH];
  logic [7:0] rd_data_q;

  always_ff @(posedge clk_i) begin
    if (wr_i) mem_q[wr_addr_i] <= wr_data_i;
  end

  // Read register doubles as the PHY DataOut register, so it resets.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) rd_data_q <= 8'h00;
    else if (rd_i) rd_data_q <= mem_q[rd_addr_i];
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/pw_utmi_tx.sv
// UTMI transmit engine: replays one prebuilt USB packet from a local buffer.
// Ports: buffer write, len/gap/start/abort control, UTMI rx/tx handshake, status.
module pw_utmi_tx
  import pw_utmi_tx_pkg::*;
#(
  parameter int pADDR_WIDTH   = 6,
  parameter int pSETUP_CYCLES = 4,
  parameter int pTAIL_CYCLES  = 16
) (
  input  logic                   fe_clk,
  input  logic                   reset_i,
  input  logic                   I_buf_wr,
  input  logic [pADDR_WIDTH-1:0] I_buf_addr,
  input  logic [7:0]             I_buf_data,
  input  logic [pADDR_WIDTH:0]   I_len,
  input  logic [7:0]             I_gap,
  input  logic                   I_start,
  input  logic                   I_abort,
  input  logic                   fe_rxactive,
  input  logic                   fe_txrdy,
  output logic [7:0]             O_tx_data,
  output logic                   O_txvalid,
  output logic [1:0]             O_opmode,
  output logic                   O_busy,
  output logic                   O_done,
  output logic                   O_aborted,
  output logic                   O_wr_blocked
);

  localparam logic [pADDR_WIDTH:0] LEN_MAX =
    (pADDR_WIDTH+1)'(2 ** pADDR_WIDTH);
  localparam logic [7:0] SETUP_LAST = 8'(pSETUP_CYCLES - 1);
  localparam logic [7:0] TAIL_LAST  = 8'(pTAIL_CYCLES - 1);

  tx_state_e              state_q;
  logic [pADDR_WIDTH:0]   len_q;
  logic [pADDR_WIDTH:0]   idx_q;
  logic [7:0]             gap_q;
  logic [7:0]             cnt_q;
  logic                   abt_q;
  logic                   txvalid_q;
  logic [1:0]             opmode_q;
  logic                   done_q;
  logic                   aborted_q;
  logic                   wr_blocked_q;

  logic                   idle;
  logic                   abort_ok;
  logic                   advance;
  logic                   last;
  logic [pADDR_WIDTH:0]   idx_nxt;
  logic [pADDR_WIDTH:0]   start_len;
  logic [pADDR_WIDTH-1:0] rd_addr;
  logic                   buf_wr;

  assign idle      = (state_q == ST_IDLE);
  assign abort_ok  = I_abort &&
                     (state_q == ST_SETUP ||
                      state_q == ST_GAP   ||
                      state_q == ST_SEND);
  assign advance   = (state_q == ST_SEND) && fe_txrdy && !I_abort;
  assign idx_nxt   = idx_q + 1'b1;
  assign last      = (idx_nxt == len_q);
  assign start_len = (I_len > LEN_MAX) ? LEN_MAX : I_len;
  assign buf_wr    = I_buf_wr && idle;

  // Read one address ahead on an accepted byte so the next byte is
  // already on DataOut in the following cycle.
  assign rd_addr = advance ? idx_nxt[pADDR_WIDTH-1:0]
                           : idx_q[pADDR_WIDTH-1:0];

  pw_utmi_tx_buffer #(
    .pADDR_WIDTH(pADDR_WIDTH)
  ) u_buf (
    .clk_i     (fe_clk),
    .rst_i     (reset_i),
    .wr_i      (buf_wr),
    .wr_addr_i (I_buf_addr),
    .wr_data_i (I_buf_data),
    .rd_i      (!idle),
    .rd_addr_i (rd_addr),
    .rd_data_o (O_tx_data)
  );

  always_ff @(posedge fe_clk or posedge reset_i) begin
    if (reset_i) begin
      state_q      <= ST_IDLE;
      len_q        <= '0;
      idx_q        <= '0;
      gap_q        <= 8'h00;
      cnt_q        <= 8'h00;
      abt_q        <= 1'b0;
      txvalid_q    <= 1'b0;
      opmode_q     <= OPMODE_NONDRIVING;
      done_q       <= 1'b0;
      aborted_q    <= 1'b0;
      wr_blocked_q <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      if (I_buf_wr && !idle) wr_blocked_q <= 1'b1;
      if (abort_ok) begin
        // Abort beats a same-cycle last-byte accept.
        txvalid_q <= 1'b0;
        state_q   <= ST_TAIL;
        cnt_q     <= 8'h00;
        abt_q     <= 1'b1;
        aborted_q <= 1'b1;
      end else begin
        unique case (state_q)
          ST_IDLE: begin
            if (I_start) begin
              wr_blocked_q <= 1'b0;
              idx_q        <= '0;
              cnt_q        <= 8'h00;
              abt_q        <= 1'b0;
              gap_q        <= I_gap;
              len_q        <= start_len;
              if (start_len == '0) begin
                done_q <= 1'b1;
              end else begin
                state_q  <= ST_SETUP;
                opmode_q <= OPMODE_NORMAL;
              end
            end
          end
          ST_SETUP: begin
            if (cnt_q == SETUP_LAST) begin
              state_q <= ST_GAP;
              cnt_q   <= 8'h00;
            end else begin
              cnt_q <= cnt_q + 8'd1;
            end
          end
          ST_GAP: begin
            // Leave on the cycle that completes the quiet run.
            if (gap_q == 8'h00 ||
                (!fe_rxactive && (cnt_q + 8'd1) == gap_q)) begin
              state_q   <= ST_SEND;
              txvalid_q <= 1'b1;
            end else if (fe_rxactive) begin
              cnt_q <= 8'h00;
            end else begin
              cnt_q <= cnt_q + 8'd1;
            end
          end
          ST_SEND: begin
            if (fe_txrdy) begin
              idx_q <= idx_nxt;
              if (last) begin
                txvalid_q <= 1'b0;
                state_q   <= ST_TAIL;
                cnt_q     <= 8'h00;
              end
            end
          end
          ST_TAIL: begin
            if (cnt_q == TAIL_LAST) begin
              opmode_q <= OPMODE_NONDRIVING;
              done_q   <= !abt_q;
              state_q  <= ST_IDLE;
            end else begin
              cnt_q <= cnt_q + 8'd1;
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign O_txvalid    = txvalid_q;
  assign O_opmode     = opmode_q;
  assign O_busy       = !idle;
  assign O_done       = done_q;
  assign O_aborted    = aborted_q;
  assign O_wr_blocked = wr_blocked_q;

endmodule

// File: tb/tb_pw_utmi_tx.sv
// Directed bench for pw_utmi_tx.
// Scenario tasks run in sequence; one summary line at the end.
module tb_pw_utmi_tx;

  logic       fe_clk = 1'b0;
  logic       reset_i;
  logic       I_buf_wr;
  logic [5:0] I_buf_addr;
  logic [7:0] I_buf_data;
  logic [6:0] I_len;
  logic [7:0] I_gap;
  logic       I_start;
  logic       I_abort;
  logic       fe_rxactive;
  logic       fe_txrdy;
  logic [7:0] O_tx_data;
  logic       O_txvalid;
  logic [1:0] O_opmode;
  logic       O_busy;
  logic       O_done;
  logic       O_aborted;
  logic       O_wr_blocked;

  pw_utmi_tx #(
    .pADDR_WIDTH(6),
    .pSETUP_CYCLES(4),
    .pTAIL_CYCLES(16)
  ) dut (
    .fe_clk       (fe_clk),
    .reset_i      (reset_i),
    .I_buf_wr     (I_buf_wr),
    .I_buf_addr   (I_buf_addr),
    .I_buf_data   (I_buf_data),
    .I_len        (I_len),
    .I_gap        (I_gap),
    .I_start      (I_start),
    .I_abort      (I_abort),
    .fe_rxactive  (fe_rxactive),
    .fe_txrdy     (fe_txrdy),
    .O_tx_data    (O_tx_data),
    .O_txvalid    (O_txvalid),
    .O_opmode     (O_opmode),
    .O_busy       (O_busy),
    .O_done       (O_done),
    .O_aborted    (O_aborted),
    .O_wr_blocked (O_wr_blocked)
  );

  always #5 fe_clk = ~fe_clk;

  int checks = 0;
  int errors = 0;

  logic [7:0] vq[$];
  logic [7:0] aq[$];
  int nvalid, ndone, nabort, nop00, first_valid;
  bit tmo;

  task automatic wr_byte(input logic [5:0] a, input logic [7:0] d);
    @(negedge fe_clk);
    I_buf_wr = 1'b1; I_buf_addr = a; I_buf_data = d;
    @(negedge fe_clk);
    I_buf_wr = 1'b0;
  endtask

  task automatic start_pkt(input logic [6:0] len, input logic [7:0] gap);
    @(negedge fe_clk);
    I_start = 1'b1; I_len = len; I_gap = gap;
  endtask

  // Plays the PHY until the engine is idle again, recording activity.
  task automatic run_pkt(input int period, input int abort_at,
                         input int max_cyc);
    int k;
    int acc;
    bit ab;
    vq.delete(); aq.delete();
    nvalid = 0; ndone = 0; nabort = 0; nop00 = 0;
    first_valid = -1; tmo = 1'b1;
    k = 0; acc = 0; ab = 1'b0;
    for (int c = 1; c <= max_cyc; c++) begin
      @(negedge fe_clk);
      I_start = 1'b0; I_abort = 1'b0; fe_txrdy = 1'b0; I_buf_wr = 1'b0;
      if (O_done) ndone++;
      if (O_aborted) nabort++;
      if (O_opmode == 2'b00) nop00++;
      if (O_txvalid) begin
        if (first_valid < 0) first_valid = c;
        nvalid++;
        vq.push_back(O_tx_data);
        fe_txrdy = ((k % period) == 0);
        if (abort_at >= 0 && !ab && acc == abort_at) begin
          I_abort = 1'b1; ab = 1'b1;
        end
        if (fe_txrdy && !I_abort) begin
          aq.push_back(O_tx_data); acc++;
        end
        k++;
      end
      if (!O_busy) begin
        tmo = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset_i = 1'b1;
    I_buf_wr = 0; I_buf_addr = 0; I_buf_data = 0; I_len = 0; I_gap = 0;
    I_start = 0; I_abort = 0; fe_rxactive = 0; fe_txrdy = 0;
    #1;
    checks++;
    if ({O_tx_data, O_txvalid, O_opmode, O_busy, O_done, O_aborted,
         O_wr_blocked} !== {8'h00, 1'b0, 2'b01, 4'b0000}) begin
      errors++;
      $display("FAIL reset_outputs got %h %b %b %b%b%b%b", O_tx_data,
               O_txvalid, O_opmode, O_busy, O_done, O_aborted, O_wr_blocked);
    end
    @(negedge fe_clk); @(negedge fe_clk);
    reset_i = 1'b0;
  endtask

  task automatic test_basic();
    wr_byte(0, 8'hA5); wr_byte(1, 8'hC3); wr_byte(2, 8'hD2);
    start_pkt(3, 0);
    run_pkt(1, -1, 100);
    checks++;
    if (tmo) begin errors++; $display("FAIL basic_timeout got busy want idle"); end
    checks++;
    if (nvalid !== 3) begin errors++; $display("FAIL basic_nvalid got %0d want 3", nvalid); end
    checks++;
    if (vq.size() != 3 || {vq[0], vq[1], vq[2]} !== 24'hA5C3D2) begin
      errors++; $display("FAIL basic_data got size %0d want A5C3D2", vq.size());
    end
    checks++;
    if (first_valid !== 6) begin errors++; $display("FAIL basic_first_valid got %0d want 6", first_valid); end
    checks++;
    if (nop00 !== 24) begin errors++; $display("FAIL basic_opmode00 got %0d want 24", nop00); end
    checks++;
    if (ndone !== 1 || nabort !== 0) begin
      errors++; $display("FAIL basic_done got %0d/%0d want 1/0", ndone, nabort);
    end
    checks++;
    if (O_opmode !== 2'b01) begin errors++; $display("FAIL basic_opmode_end got %b want 01", O_opmode); end
  endtask

  task automatic test_slow_rdy();
    start_pkt(3, 0);
    run_pkt(3, -1, 100);
    checks++;
    if (nvalid !== 7) begin errors++; $display("FAIL slow_nvalid got %0d want 7", nvalid); end
    checks++;
    if (vq.size() != 7 ||
        {vq[0], vq[1], vq[2], vq[3], vq[4], vq[5], vq[6]} !== 56'hA5C3C3C3D2D2D2) begin
      errors++; $display("FAIL slow_hold got size %0d want A5C3C3C3D2D2D2", vq.size());
    end
    checks++;
    if (aq.size() != 3 || {aq[0], aq[1], aq[2]} !== 24'hA5C3D2) begin
      errors++; $display("FAIL slow_accept got size %0d want A5C3D2", aq.size());
    end
    checks++;
    if (nop00 !== 28 || ndone !== 1) begin
      errors++; $display("FAIL slow_tail got %0d/%0d want 28/1", nop00, ndone);
    end
  endtask

  task automatic test_gap(input int pre_low);
    int n;
    fe_rxactive = 1'b1;
    start_pkt(1, 5);
    @(negedge fe_clk);
    I_start = 1'b0;
    repeat (6) @(negedge fe_clk);
    checks++;
    if (O_txvalid !== 1'b0 || O_busy !== 1'b1) begin
      errors++; $display("FAIL gap_hold got txvalid %b busy %b want 0 1", O_txvalid, O_busy);
    end
    fe_rxactive = 1'b0;
    if (pre_low > 0) begin
      repeat (pre_low) @(negedge fe_clk);
      fe_rxactive = 1'b1;
      @(negedge fe_clk);
      fe_rxactive = 1'b0;
    end
    n = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge fe_clk);
      if (O_txvalid) begin n = k; break; end
    end
    checks++;
    if (n !== 5) begin
      errors++; $display("FAIL gap_count_%0d got %0d want 5", pre_low, n);
    end
    fe_txrdy = 1'b1;
    run_pkt(1, -1, 60);
    checks++;
    if (tmo || ndone !== 1) begin
      errors++; $display("FAIL gap_done_%0d got %0d want 1", pre_low, ndone);
    end
  endtask

  task automatic test_len_edge();
    int bad;
    @(negedge fe_clk);
    I_start = 1'b1; I_len = 0; I_gap = 0;
    @(negedge fe_clk);
    I_start = 1'b0;
    checks++;
    if ({O_done, O_busy, O_txvalid, O_opmode} !== 5'b10001) begin
      errors++;
      $display("FAIL len0_done got %b%b%b%b want 10001", O_done, O_busy, O_txvalid, O_opmode);
    end
    @(negedge fe_clk);
    checks++;
    if (O_done !== 1'b0 || O_busy !== 1'b0) begin
      errors++; $display("FAIL len0_pulse got %b%b want 00", O_done, O_busy);
    end
    for (int i = 0; i < 64; i++) wr_byte(6'(i), 8'(i * 7 + 3));
    start_pkt(100, 0);
    run_pkt(1, -1, 200);
    checks++;
    if (nvalid !== 64 || aq.size() != 64) begin
      errors++; $display("FAIL len64_count got %0d want 64", nvalid);
    end
    bad = 0;
    for (int i = 0; i < aq.size(); i++)
      if (aq[i] !== 8'(i * 7 + 3)) bad++;
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL len64_data got %0d bad want 0", bad); end
    checks++;
    if (nop00 !== 85 || ndone !== 1) begin
      errors++; $display("FAIL len64_tail got %0d/%0d want 85/1", nop00, ndone);
    end
  endtask

  task automatic test_abort();
    for (int i = 0; i < 8; i++) wr_byte(6'(i), 8'(8'h10 + i));
    start_pkt(8, 0);
    run_pkt(1, 2, 100);
    checks++;
    if (nvalid !== 3 || aq.size() != 2) begin
      errors++; $display("FAIL abort_stop got %0d/%0d want 3/2", nvalid, aq.size());
    end
    checks++;
    if (nabort !== 1 || ndone !== 0) begin
      errors++; $display("FAIL abort_pulse got %0d/%0d want 1/0", nabort, ndone);
    end
    checks++;
    if (nop00 !== 24 || O_opmode !== 2'b01) begin
      errors++; $display("FAIL abort_tail got %0d %b want 24 01", nop00, O_opmode);
    end
    start_pkt(3, 0);
    run_pkt(1, 2, 100);
    checks++;
    if (nvalid !== 3 || nabort !== 1 || ndone !== 0) begin
      errors++;
      $display("FAIL abort_last got %0d/%0d/%0d want 3/1/0", nvalid, nabort, ndone);
    end
  endtask

  task automatic test_blocked();
    bit seen;
    start_pkt(4, 0);
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge fe_clk);
      I_start = 1'b0;
      if (O_txvalid) begin seen = 1'b1; break; end
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL blk_send got no txvalid want txvalid"); end
    I_buf_wr = 1'b1; I_buf_addr = 0; I_buf_data = 8'hFF;
    I_start = 1'b1; I_len = 1;
    @(negedge fe_clk);
    I_buf_wr = 1'b0; I_start = 1'b0;
    checks++;
    if ({O_wr_blocked, O_txvalid, O_busy, O_done} !== 4'b1110) begin
      errors++;
      $display("FAIL blk_flag got %b%b%b%b want 1110", O_wr_blocked, O_txvalid, O_busy, O_done);
    end
    run_pkt(1, -1, 100);
    checks++;
    if (aq.size() != 4 || aq[0] !== 8'h10 || ndone !== 1) begin
      errors++; $display("FAIL blk_ignored got size %0d want 4 bytes from 10", aq.size());
    end
    checks++;
    if (O_wr_blocked !== 1'b1) begin errors++; $display("FAIL blk_sticky got %b want 1", O_wr_blocked); end
    @(negedge fe_clk);
    I_buf_wr = 1'b1; I_buf_addr = 0; I_buf_data = 8'h5A;
    I_start = 1'b1; I_len = 1; I_gap = 0;
    run_pkt(1, -1, 60);
    checks++;
    if (aq.size() != 1 || aq[0] !== 8'h5A) begin
      errors++; $display("FAIL wr_start got size %0d want 1 byte 5A", aq.size());
    end
    checks++;
    if (O_wr_blocked !== 1'b0) begin errors++; $display("FAIL blk_clear got %b want 0", O_wr_blocked); end
  endtask

  task automatic test_reset_mid_send();
    bit seen;
    start_pkt(4, 0);
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge fe_clk);
      I_start = 1'b0;
      if (O_txvalid) begin seen = 1'b1; break; end
    end
    fe_txrdy = 1'b0;
    #2;
    reset_i = 1'b1;
    #1;
    checks++;
    if (!seen || {O_txvalid, O_opmode, O_busy, O_tx_data} !== {1'b0, 2'b01, 1'b0, 8'h00}) begin
      errors++;
      $display("FAIL rst_async got %b %b %b %h want 0 01 0 00", O_txvalid, O_opmode, O_busy, O_tx_data);
    end
    @(negedge fe_clk);
    reset_i = 1'b0;
    @(negedge fe_clk);
    checks++;
    if (O_busy !== 1'b0 || O_txvalid !== 1'b0) begin
      errors++; $display("FAIL rst_idle got %b%b want 00", O_busy, O_txvalid);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_slow_rdy();
    test_gap(0);
    test_gap(3);
    test_len_edge();
    test_abort();
    test_blocked();
    test_reset_mid_send();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
